// File: rtl/pll_reset_seq_pkg.sv
// ---------------------------------------------------------------------------
// pll_rst_pkg
// Shared definitions for the PLL reset sequencer:
//   state_t       - FSM state encoding (WAIT_LOCK=0, STABLE=1, RUN=2, HOLD=3)
//   timer_width() - width of the shared STABLE/HOLD timer
// No ports (package).
// ---------------------------------------------------------------------------
package pll_rst_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STABLE    = 2'd1,
        ST_RUN       = 2'd2,
        ST_HOLD      = 2'd3
    } state_t;

    // One timer serves both the STABLE and HOLD windows, so it is sized for the
    // longer one. A single-cycle window still needs a one-bit timer.
    function automatic int timer_width(input int a_cycles, input int b_cycles);
        int v_max;
        v_max = (a_cycles > b_cycles) ? a_cycles : b_cycles;
        if (v_max <= 1) begin
            return 1;
        end else begin
            return $clog2(v_max);
        end
    endfunction

endpackage : pll_rst_pkg

// File: rtl/pll_reset_seq_sync_ff.sv
// ---------------------------------------------------------------------------
// sync_ff
// Multi-stage flop synchronizer for a single asynchronous level signal.
// Ports:
//   i_clk    - destination clock
//   i_rst_n  - asynchronous active-low reset, clears every stage to 0
//   i_d      - asynchronous input
//   o_q      - synchronized output (last stage)
// ---------------------------------------------------------------------------
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    // Shift the async input through the flop chain; only the last stage is used.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule : sync_ff

// File: rtl/pll_reset_seq.sv
// ---------------------------------------------------------------------------
// pll_reset_seq
// Per-clock-domain reset sequencer placed between a PLL output and the logic
// it clocks. The PLL lock flag is synchronized, downstream reset is released
// only after lock has been stable for STABLE_CYCLES, and it is reasserted for
// at least HOLD_CYCLES whenever lock is lost while running.
// Ports:
//   clk              - domain clock (PLL output)
//   rst_n            - asynchronous active-low reset
//   pll_locked       - PLL lock flag, asynchronous to clk
//   rst_out          - active-high reset to downstream logic
//   ready            - 1 while downstream logic runs (state RUN)
//   lock_loss_count  - saturating count of RUN -> lock-lost events
//   status_led       - health LED: steady in healthy RUN, blinking after a loss
// ---------------------------------------------------------------------------
module pll_reset_seq
    import pll_rst_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1024,
    parameter int HOLD_CYCLES   = 16,
    parameter int CNT_W         = 8,
    parameter int LED_DIV       = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_locked,
    output logic             rst_out,
    output logic             ready,
    output logic [CNT_W-1:0] lock_loss_count,
    output logic             status_led
);

    localparam int TMR_W = timer_width(STABLE_CYCLES, HOLD_CYCLES);
    localparam logic [TMR_W-1:0] STABLE_LAST = TMR_W'(STABLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST   = TMR_W'(HOLD_CYCLES - 1);

    logic               w_lock_s;

    state_t             r_state;
    logic [TMR_W-1:0]   r_timer;
    logic [CNT_W-1:0]   r_count;
    logic [LED_DIV-1:0] r_led_cnt;
    logic               r_rst_out;
    logic               r_ready;
    logic               r_status_led;

    state_t             w_state_next;
    logic [TMR_W-1:0]   w_timer_next;
    logic [CNT_W-1:0]   w_count_next;
    logic [LED_DIV-1:0] w_led_cnt_next;
    logic               w_led_next;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_d     (pll_locked),
        .o_q     (w_lock_s)
    );

    // Next-state, timer and loss-counter decode for the sequencer FSM.
    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_count_next = r_count;
        case (r_state)
            ST_WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_state_next = ST_STABLE;
                    w_timer_next = '0;
                end else begin
                    w_timer_next = '0;
                end
            end
            ST_STABLE: begin
                // A lock drop here is not counted: the domain never ran.
                if (!w_lock_s) begin
                    w_state_next = ST_WAIT_LOCK;
                    w_timer_next = '0;
                end else if (r_timer == STABLE_LAST) begin
                    w_state_next = ST_RUN;
                    w_timer_next = '0;
                end else begin
                    w_timer_next = r_timer + TMR_W'(1);
                end
            end
            ST_RUN: begin
                if (!w_lock_s) begin
                    w_state_next = ST_HOLD;
                    w_timer_next = '0;
                    w_count_next = (r_count == '1) ? r_count : (r_count + CNT_W'(1));
                end else begin
                    w_timer_next = '0;
                end
            end
            ST_HOLD: begin
                // Lock is deliberately ignored so a quick relock cannot shorten HOLD.
                if (r_timer == HOLD_LAST) begin
                    w_state_next = ST_WAIT_LOCK;
                    w_timer_next = '0;
                end else begin
                    w_timer_next = r_timer + TMR_W'(1);
                end
            end
            default: begin
                w_state_next = ST_WAIT_LOCK;
                w_timer_next = '0;
            end
        endcase
    end

    // LED decode from the next state so the LED moves on the same edge as the FSM.
    always_comb begin
        w_led_cnt_next = r_led_cnt + LED_DIV'(1);
        if (w_state_next != ST_RUN) begin
            w_led_next = 1'b0;
        end else if (w_count_next == '0) begin
            w_led_next = 1'b1;
        end else begin
            w_led_next = w_led_cnt_next[LED_DIV-1];
        end
    end

    // FSM state plus all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_WAIT_LOCK;
            r_timer      <= '0;
            r_count      <= '0;
            r_led_cnt    <= '0;
            r_rst_out    <= 1'b1;
            r_ready      <= 1'b0;
            r_status_led <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_timer      <= w_timer_next;
            r_count      <= w_count_next;
            r_led_cnt    <= w_led_cnt_next;
            r_rst_out    <= (w_state_next != ST_RUN);
            r_ready      <= (w_state_next == ST_RUN);
            r_status_led <= w_led_next;
        end
    end

    assign rst_out         = r_rst_out;
    assign ready           = r_ready;
    assign lock_loss_count = r_count;
    assign status_led      = r_status_led;

endmodule : pll_reset_seq
